// File: rtl/gpio_pin_arbiter_pkg.sv
// Shared constants and types for the GPIO pin arbiter: requester indices,
// per-requester pin groups and the FSM / event encodings.
package gpio_arb_pkg;

  localparam int N_REQ = 6;
  localparam int PIN_W = 16;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  localparam int REQ_PWM_A0  = 0;
  localparam int REQ_PWM_B0  = 1;
  localparam int REQ_TMR_IN0 = 2;
  localparam int REQ_I2C     = 3;
  localparam int REQ_SPI     = 4;
  localparam int REQ_UART    = 5;

  // PWM_B0 and TMR_IN0 share pin 1; I2C and SPI share pin 4.
  localparam logic [PIN_W-1:0] PIN_MASK [N_REQ] = '{
    16'h0001,  // PWM_A0
    16'h0002,  // PWM_B0
    16'h0002,  // TMR_IN0
    16'h0018,  // I2C
    16'h00F0,  // SPI
    16'h0300   // UART
  };

  typedef enum logic {IDLE, GUARD} arb_state_e;
  typedef enum logic {EV_GRANT, EV_RELEASE} arb_event_e;

  // Union of the pin groups of every selected requester.
  function automatic logic [PIN_W-1:0] mask_of(input logic [N_REQ-1:0] sel);
    logic [PIN_W-1:0] m;
    m = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel[i]) m = m | PIN_MASK[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_pin_arbiter_if.sv
// Request/ownership bundle between the peripherals' control side and the
// pin arbiter. The arbiter sits on the slave modport.
interface gpio_pin_arbiter_if;
  import gpio_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             cfg_lock;
  logic [N_REQ-1:0] grant;
  logic [PIN_W-1:0] owned_mask;
  logic [PIN_W-1:0] park_mask;
  logic             busy;

  modport master (
    output req, cfg_lock,
    input  grant, owned_mask, park_mask, busy
  );

  modport slave (
    input  req, cfg_lock,
    output grant, owned_mask, park_mask, busy
  );
endinterface

// File: rtl/gpio_pin_arbiter_rr_picker.sv
// Combinational round-robin picker: first set candidate at or above rr_ptr,
// wrapping past the top requester back to 0.
module gpio_rr_picker
  import gpio_arb_pkg::*;
(
  input  logic [N_REQ-1:0] cand,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  // Walk offsets from farthest to nearest so the nearest candidate wins.
  always_comb begin
    int idx;
    idx    = 0;
    valid  = 1'b0;
    winner = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr) + off) % N_REQ;
      if (cand[idx]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/gpio_pin_arbiter.sv
// GPIO pin arbiter: hands non-overlapping pin groups to six peripherals,
// parking the affected pins as inputs for a guard window on every
// ownership change. Releases take priority over new grants.
//
//   state | meaning
//   IDLE  | evaluate one release or one grant per cycle
//   GUARD | pins of the current event parked; counting down the window
module gpio_pin_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int GUARD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  gpio_pin_arbiter_if.slave   bus
);

  arb_state_e       state_q, state_d;
  arb_event_e       ev_q, ev_d;
  logic [IDX_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PIN_W-1:0] owned_q, owned_d;
  logic [PIN_W-1:0] park_q, park_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] rel_vec;
  logic [IDX_W-1:0] rel_idx;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  // Requesters not yet granted whose pins are all free; lowest pending release.
  always_comb begin
    cand    = '0;
    rel_vec = bus.req ^ bus.req | (grant_q & ~bus.req);
    rel_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand[i] = bus.req[i] & ~grant_q[i] & ~(|(PIN_MASK[i] & owned_q));
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rel_vec[i]) rel_idx = IDX_W'(i);
    end
  end

  gpio_rr_picker u_picker (
    .cand   (cand),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Next-state and output decisions for the release/grant sequencing.
  always_comb begin
    state_d  = state_q;
    ev_d     = ev_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    owned_d  = owned_q;
    park_d   = park_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (|rel_vec) begin
          // Released pins stay in owned_mask until the guard window ends.
          grant_d[rel_idx] = 1'b0;
          park_d           = PIN_MASK[rel_idx];
          ev_d             = EV_RELEASE;
          state_d          = GUARD;
          cnt_d            = CNT_W'(GUARD_CYCLES - 1);
          busy_d           = 1'b1;
        end else if (!bus.cfg_lock && pick_valid) begin
          pend_d   = pick_idx;
          owned_d  = owned_q | PIN_MASK[pick_idx];
          park_d   = PIN_MASK[pick_idx];
          rr_ptr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          ev_d     = EV_GRANT;
          state_d  = GUARD;
          cnt_d    = CNT_W'(GUARD_CYCLES - 1);
          busy_d   = 1'b1;
        end
      end
      GUARD: begin
        if (cnt_q == '0) begin
          if (ev_q == EV_GRANT) grant_d[pend_q] = 1'b1;
          owned_d = mask_of(grant_d);
          park_d  = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything without a guard run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ev_q     <= EV_GRANT;
      pend_q   <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      owned_q  <= '0;
      park_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ev_q     <= ev_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      owned_q  <= owned_d;
      park_q   <= park_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.owned_mask = owned_q;
  assign bus.park_mask  = park_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_gpio_pin_arbiter.sv
// Bench for gpio_pin_arbiter: a table of timed vectors plus hand-written
// corner sequences, all routed through an expectation queue.
module tb_gpio_pin_arbiter;
  import gpio_arb_pkg::*;

  localparam int G = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  gpio_pin_arbiter_if bus ();

  gpio_pin_arbiter #(.GUARD_CYCLES(G)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  grant;
    logic [15:0] owned;
    logic [15:0] park;
    logic        busy;
  } obs_t;

  typedef struct {
    logic [5:0] req;
    logic       lock;
    int         cycles;
    obs_t       exp;
  } vec_t;

  obs_t  sb_q[$];
  string sb_name[$];
  vec_t  vt[17];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input logic [5:0] g, input logic [15:0] o,
                          input logic [15:0] p, input logic b);
    obs_t e;
    e.grant = g; e.owned = o; e.park = p; e.busy = b;
    sb_q.push_back(e);
    sb_name.push_back(name);
  endtask

  task automatic pop_check();
    obs_t  e;
    string n;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      n = sb_name.pop_front();
      chk16({n, " grant"}, 16'(bus.grant), 16'(e.grant));
      chk16({n, " owned"}, bus.owned_mask, e.owned);
      chk16({n, " park"},  bus.park_mask,  e.park);
      chk16({n, " busy"},  16'(bus.busy),  16'(e.busy));
    end
  endtask

  task automatic step(input string name, input logic [5:0] r, input logic l, input int cyc,
                      input logic [5:0] g, input logic [15:0] o, input logic [15:0] p,
                      input logic b);
    bus.req      = r;
    bus.cfg_lock = l;
    push_exp(name, g, o, p, b);
    tick(cyc);
    pop_check();
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    bus.req      = '0;
    bus.cfg_lock = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  initial begin
    // req, lock, cycles, {grant, owned, park, busy}
    vt[0]  = '{6'b000001, 1'b0, 1, '{6'b000001 ^ 6'b000001, 16'h0001, 16'h0001, 1'b1}};
    vt[1]  = '{6'b000001, 1'b0, 3, '{6'b000000, 16'h0001, 16'h0001, 1'b1}};
    vt[2]  = '{6'b000001, 1'b0, 1, '{6'b000001, 16'h0001, 16'h0000, 1'b0}};
    vt[3]  = '{6'b001001, 1'b0, 1, '{6'b000001, 16'h0019, 16'h0018, 1'b1}};
    vt[4]  = '{6'b001001, 1'b0, 4, '{6'b001001, 16'h0019, 16'h0000, 1'b0}};
    vt[5]  = '{6'b011001, 1'b0, 6, '{6'b001001, 16'h0019, 16'h0000, 1'b0}};
    vt[6]  = '{6'b010001, 1'b0, 1, '{6'b000001, 16'h0019, 16'h0018, 1'b1}};
    vt[7]  = '{6'b010001, 1'b0, 3, '{6'b000001, 16'h0019, 16'h0018, 1'b1}};
    vt[8]  = '{6'b010001, 1'b0, 1, '{6'b000001, 16'h0001, 16'h0000, 1'b0}};
    vt[9]  = '{6'b010001, 1'b0, 1, '{6'b000001, 16'h00F1, 16'h00F0, 1'b1}};
    vt[10] = '{6'b010001, 1'b0, 4, '{6'b010001, 16'h00F1, 16'h0000, 1'b0}};
    vt[11] = '{6'b110001, 1'b0, 5, '{6'b110001, 16'h03F1, 16'h0000, 1'b0}};
    vt[12] = '{6'b010000, 1'b0, 1, '{6'b110000, 16'h03F1, 16'h0001, 1'b1}};
    vt[13] = '{6'b010000, 1'b0, 4, '{6'b110000, 16'h03F0, 16'h0000, 1'b0}};
    vt[14] = '{6'b010000, 1'b0, 1, '{6'b010000, 16'h03F0, 16'h0300, 1'b1}};
    vt[15] = '{6'b010000, 1'b0, 4, '{6'b010000, 16'h00F0, 16'h0000, 1'b0}};
    vt[16] = '{6'b000000, 1'b0, 5, '{6'b000000, 16'h0000, 16'h0000, 1'b0}};

    do_reset();
    push_exp("reset", '0, '0, '0, 1'b0);
    pop_check();
    chk16("reset rr_ptr", 16'(dut.rr_ptr_q), 16'd0);

    for (int i = 0; i < 17; i++) begin
      step($sformatf("vec%0d", i), vt[i].req, vt[i].lock, vt[i].cycles,
           vt[i].exp.grant, vt[i].exp.owned, vt[i].exp.park, vt[i].exp.busy);
    end

    // Shared pin 1: PWM_B0 wins from rr_ptr 0, TMR_IN0 waits for its release.
    do_reset();
    step("rr ev",      6'b000110, 1'b0, 1, 6'b000000, 16'h0002, 16'h0002, 1'b1);
    step("rr b0",      6'b000110, 1'b0, 4, 6'b000010, 16'h0002, 16'h0000, 1'b0);
    chk16("rr ptr b0", 16'(dut.rr_ptr_q), 16'd2);
    step("rr blocked", 6'b000110, 1'b0, 3, 6'b000010, 16'h0002, 16'h0000, 1'b0);
    step("rr rel",     6'b000100, 1'b0, 1, 6'b000000, 16'h0002, 16'h0002, 1'b1);
    step("rr relend",  6'b000100, 1'b0, 4, 6'b000000, 16'h0000, 16'h0000, 1'b0);
    step("rr tmr ev",  6'b000100, 1'b0, 1, 6'b000000, 16'h0002, 16'h0002, 1'b1);
    step("rr tmr",     6'b000100, 1'b0, 4, 6'b000100, 16'h0002, 16'h0000, 1'b0);
    chk16("rr ptr tmr", 16'(dut.rr_ptr_q), 16'd3);

    // cfg_lock holds off UART; grant lands GUARD+1 cycles after unlock.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step($sformatf("lock c%0d", c), 6'b100000, 1'b1, 1, 6'b000000, 16'h0000, 16'h0000, 1'b0);
    end
    step("unlock guard", 6'b100000, 1'b0, G, 6'b000000, 16'h0300, 16'h0300, 1'b1);
    step("unlock grant", 6'b100000, 1'b0, 1, 6'b100000, 16'h0300, 16'h0000, 1'b0);

    // cfg_lock rising mid-guard does not cancel the pending grant.
    do_reset();
    step("lockg ev",   6'b000001, 1'b0, 1, 6'b000000, 16'h0001, 16'h0001, 1'b1);
    step("lockg done", 6'b000001, 1'b1, G, 6'b000001, 16'h0001, 16'h0000, 1'b0);

    // Request dropped during its own grant guard: granted, then released.
    do_reset();
    step("drop ev",    6'b001000, 1'b0, 1, 6'b000000, 16'h0018, 16'h0018, 1'b1);
    step("drop grant", 6'b000000, 1'b0, G, 6'b001000, 16'h0018, 16'h0000, 1'b0);
    step("drop rel",   6'b000000, 1'b0, 1, 6'b000000, 16'h0018, 16'h0018, 1'b1);
    step("drop end",   6'b000000, 1'b0, G, 6'b000000, 16'h0000, 16'h0000, 1'b0);

    // Asynchronous reset in the middle of a grant guard.
    do_reset();
    step("rst ev", 6'b000001, 1'b0, 2, 6'b000000, 16'h0001, 16'h0001, 1'b1);
    reset = 1'b0;
    push_exp("rst async", '0, '0, '0, 1'b0);
    #1;
    pop_check();
    bus.req = '0;
    tick(1);
    reset = 1'b1;
    step("post rst", 6'b000000, 1'b0, 8, 6'b000000, 16'h0000, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_pin_arbiter.md
# gpio_pin_arbiter

- Shares the 16 GPIO pins among six on-chip peripherals: PWM_A0, PWM_B0, TMR_IN0, I2C, SPI and UART.
- Each peripheral requests a fixed pin group with a level request; grants are round-robin and never give overlapping pins to two owners.
- Every ownership change passes through a guard window in which the affected pins are parked as inputs.
- The grant vector drives the peripheral-enable inputs of the special-pins mux; `park_mask` forces direction to input in the pin datapath.

## Interface

Parameters:
- `N_REQ`, 6 — number of requesters; fixed by package mapping.
- `GUARD_CYCLES`, 4 — park window length in clk cycles; legal range 1..15.

Ports:
- `clk`  in  1 — single clock, rising edge.
- `reset`  in  1 — asynchronous, active-low reset.
- `req`  in  N_REQ — level request per peripheral. Bit order: 0 PWM_A0, 1 PWM_B0, 2 TMR_IN0, 3 I2C, 4 SPI, 5 UART.
- `cfg_lock`  in  1 — when high, no new grants are issued; releases are still processed.
- `grant`  out  N_REQ — ownership per requester; bit i is the enable for peripheral i.
- `owned_mask`  out  16 — OR of the pin masks of granted requesters plus the pending winner.
- `park_mask`  out  16 — pins currently in the guard window; these are forced to input.
- `busy`  out  1 — high while in GUARD.

## Operation

Pin masks (package constants):
- PWM_A0 {0}
- PWM_B0 {1}
- TMR_IN0 {1}
- I2C {3,4}
- SPI {4,5,6,7}
- UART {8,9}
- Conflicting pairs: PWM_B0/TMR_IN0 and I2C/SPI.

FSM states:
- IDLE: at most one event is evaluated per cycle.
  - Release has priority over grant.
  - If any i has `grant[i]=1` and `req[i]=0`: release the lowest such i, clear `grant[i]`, set `park_mask`=MASK[i], go to GUARD.
  - Otherwise, if `cfg_lock=0`, form candidates = `req & ~grant` with `MASK[i] & owned_mask == 0`. If any candidate exists, pick the winner round-robin starting at `rr_ptr`, upward with wrap. Record it as pending, add MASK[winner] to `owned_mask`, set `park_mask`=MASK[winner], set `rr_ptr`=(winner+1) mod N_REQ, go to GUARD.
  - Otherwise, stay in IDLE.
- GUARD: counter counts GUARD_CYCLES cycles. On the last cycle:
  - If the event was a grant, set `grant[pending]`.
  - Clear `park_mask` and return to IDLE.
  - `req` and `cfg_lock` are ignored while in GUARD.

Boundary behaviour:
- Requester drops `req` during its own grant guard: the grant is still asserted at the end of the guard, then released on the next IDLE cycle.
- Conflicting requesters stay pending until the owner releases; no starvation is guaranteed because of the rr pointer.
- Simultaneous release and request: the release is serviced first; the request is evaluated on the next IDLE cycle.
- `cfg_lock` rising during GUARD: the pending grant still completes.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); no guard window is run.
- Reset values: `grant`=0, `owned_mask`=0, `park_mask`=0, `busy`=0, FSM=IDLE, `rr_ptr`=0, counter=0.

## Timing

- All outputs are registered.
- Grant latency: `req[i]` is sampled high at edge k (IDLE, no conflict, unlocked).
  - After edge k: `park_mask`=MASK[i] and `busy`=1.
  - After edge k+GUARD_CYCLES: `grant[i]`=1, `park_mask`=0, `busy`=0.
- Release latency: `req[i]` is sampled low at edge k (IDLE).
  - After edge k: `grant[i]`=0, `park_mask`=MASK[i].
  - After edge k+GUARD_CYCLES: `park_mask`=0, and MASK[i] is removed from `owned_mask`.
- Minimum spacing between events is GUARD_CYCLES+1 cycles.
- Peripherals must not drive their pins until they see `grant` high.

## Structure

- Package `gpio_arb_pkg` holds:
  - N_REQ
  - requester index constants
  - the PIN_MASK array of 16-bit masks
  - the FSM state enum (IDLE, GUARD)
  - the event-type enum (EV_GRANT, EV_RELEASE)
- Sub-module `gpio_rr_picker` is combinational. It takes the candidate vector and `rr_ptr` and returns a valid flag and the winner index.

## Test plan

- Reset, then `req`=000001 with GUARD_CYCLES=4:
  - `park_mask`=0x0001 after edge 1.
  - `grant`=000001 after edge 5.
  - `owned_mask`=0x0001 from edge 1 onward.
- I2C is granted, then SPI requests: SPI stays ungranted. Drop I2C `req`:
  - `grant[3]` clears.
  - `park_mask`=0x0018 for 4 cycles.
  - Then SPI is granted, with `park_mask`=0x00F0 during its guard.
- PWM_B0 and TMR_IN0 request together from reset (`rr_ptr`=0):
  - PWM_B0 is granted first.
  - After PWM_B0 releases, TMR_IN0 is granted.
  - `rr_ptr`=3 afterwards.
- `cfg_lock`=1 with `req`=100000: no grant for 20 cycles. Deassert `cfg_lock`: UART is granted GUARD_CYCLES+1 cycles later.
- Same-cycle release of PWM_A0 and UART:
  - PWM_A0 is released first (`park_mask`=0x0001).
  - Then UART is released (`park_mask`=0x0300).
- Assert reset during a grant guard: all outputs are 0 immediately, and there is no grant after reset is released unless `req` is held.
